keypad_scan_4x4: RTL and testbench
==================================

KEYPAD_SCAN_4X4 -- requirements
Module: keypad_scan_4x4

Interface
REQ-001 The block SHALL have parameter SCAN_DIV_BITS, default 17, giving a scan tick period of 2^SCAN_DIV_BITS clk cycles.
REQ-002 The block SHALL have parameter DEBOUNCE_TICKS, default 8: consecutive stable scan ticks required to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port row, input, 4 bits: keypad row sense lines, active-low, pulled up, asynchronous to clk.
REQ-006 The block SHALL have port col, output, 4 bits: column drive, active-low one-hot.
REQ-007 The block SHALL have port key_value, output, 4 bits: code of the accepted key, equal to row_idx*4 + col_idx.
REQ-008 The block SHALL have port key_valid, output, 1 bit: high while an accepted key is held.
REQ-009 The block SHALL have port key_pulse, output, 1 bit: one-clk pulse on each newly accepted press.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before any use; "row" below means the synchronized value.
REQ-011 A free-running SCAN_DIV_BITS-wide divider SHALL produce tick, a one-clk pulse on each rising edge of its MSB.
REQ-012 All state, counter and output updates other than the synchronizer, the divider and key_pulse clearing SHALL occur only on clk edges where tick=1.
REQ-013 col index 0 SHALL correspond to col=4'b1110, with 1101=1, 1011=2 and 0111=3.
REQ-014 The FSM SHALL have exactly four states: SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-015 SCAN, on tick: if row==4'b1111, col SHALL rotate 1110->1101->1011->0111->1110.
REQ-016 SCAN, on tick: otherwise the block SHALL capture row_idx (lowest-index low row wins) and the current col_idx, set debounce count=1, and go to PRESS_DB with col frozen.
REQ-017 PRESS_DB, on tick: if row equals the captured row pattern, the count SHALL increment.
REQ-018 PRESS_DB: on the tick where the count reaches DEBOUNCE_TICKS, the block SHALL go to HELD, load key_value, set key_valid=1 and pulse key_pulse for exactly one clk.
REQ-019 PRESS_DB, on tick: any mismatch SHALL clear the count and return to SCAN without rotating col.
REQ-020 HELD, on tick: if row==4'b1111, the block SHALL set count=1 and go to RELEASE_DB; otherwise it SHALL remain in HELD.
REQ-021 HELD: a change of row to a different non-idle pattern SHALL be ignored; no new key is accepted until release.
REQ-022 RELEASE_DB, on tick: if row==4'b1111, the count SHALL increment; on reaching DEBOUNCE_TICKS the block SHALL clear key_valid and go to SCAN with col unchanged.
REQ-023 RELEASE_DB, on tick: any row low SHALL return to HELD with key_valid still 1 and no key_pulse.
REQ-024 key_value SHALL hold its last accepted code after release until the next accepted press.
REQ-025 col SHALL remain one-hot-low at all times; an illegal col value SHALL recover to 4'b1110 on the next tick.
REQ-026 The debounce counter SHALL be $clog2(DEBOUNCE_TICKS+1) bits wide and SHALL never wrap.

Reset
REQ-027 While reset_n=0, the block SHALL hold col=4'b1110, key_value=0, key_valid=0, key_pulse=0, state=SCAN, divider=0, count=0 and synchronizer flops=4'b1111, all asynchronously.
REQ-028 Reset asserted mid-debounce or in HELD SHALL discard the pending key, with no key_pulse after reset release.

Structure
REQ-029 The state encoding, the idle row constant 4'b1111 and the default parameter values SHALL live in shared package keypad_pkg.
REQ-030 Tick generation SHALL reuse the team's existing edge_detector_n sub-module on the divider MSB.

Verification (SCAN_DIV_BITS=4, i.e. tick every 16 clk; DEBOUNCE_TICKS=3)
REQ-031 Idle: row=1111 for 80 clk -> col steps 1110,1101,1011,0111,1110 one step per tick; key_valid=0; key_pulse never high.
REQ-032 Clean press: row=1011 while col=1101 (row2, col1) -> after 3 ticks key_value=9, key_valid=1, one key_pulse of width 1 clk, col frozen at 1101.
REQ-033 Bounce: row toggles 1011/1111 on alternate ticks -> no key_pulse; the FSM returns to SCAN; col continues rotating only on ticks where row=1111.
REQ-034 Release: after REQ-032, row=1111 for 3 ticks -> key_valid=0 on the third tick; key_value stays 9; scanning resumes from col=1101.
REQ-035 Release glitch plus two rows: in HELD, row=1111 for 1 tick then 1011 -> key_valid stays 1 with no second pulse; separately, row=1001 on press -> key_value uses row_idx 1.
REQ-036 Reset mid-PRESS_DB: drive reset_n=0 for 1 clk -> outputs return to reset values immediately; no pulse follows.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam logic [3:0] COL_INIT = 4'b1110;

  localparam int DEF_SCAN_DIV_BITS  = 17;
  localparam int DEF_DEBOUNCE_TICKS = 8;

  function automatic logic col_legal(
    input logic [3:0] c
  );
    return c inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  function automatic logic [1:0] col_idx(
    input logic [3:0] c
  );
    logic [1:0] idx;
    case (c)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Lowest-index active row wins when several are low.
  function automatic logic [1:0] row_idx(
    input logic [3:0] r
  );
    logic [1:0] idx;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/edge_detector_n.sv
// Rising-edge detector: one-clk pulse per bit on each 0->1 transition.
module edge_detector_n #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_sig,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '0;
    else        r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with tick-paced press/release debounce.
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = DEF_SCAN_DIV_BITS,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_pulse
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [3:0]               r_row_s1;
  logic [3:0]               r_row_s2;
  logic [SCAN_DIV_BITS-1:0] r_div;
  logic                     w_tick;
  kp_state_e                r_state;
  logic [CW-1:0]            r_cnt;
  logic [CW-1:0]            w_cnt_nxt;
  logic [3:0]               r_cap_row;
  logic [3:0]               r_cap_code;
  logic [3:0]               r_col;
  logic [3:0]               r_key_value;
  logic                     r_key_valid;
  logic                     r_key_pulse;
  logic [3:0]               w_row;
  logic                     w_idle;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row_s1 <= ROW_IDLE;
      r_row_s2 <= ROW_IDLE;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_div <= '0;
    else          r_div <= r_div + 1'b1;
  end

  edge_detector_n #(
    .WIDTH (1)
  ) u_tick (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_sig  (r_div[SCAN_DIV_BITS-1]),
    .o_rise (w_tick)
  );

  assign w_row  = r_row_s2;
  assign w_idle = (w_row == ROW_IDLE);

  // Saturating so the counter can never wrap.
  assign w_cnt_nxt = (r_cnt == DB_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= SCAN;
      r_cnt       <= '0;
      r_cap_row   <= ROW_IDLE;
      r_cap_code  <= '0;
      r_col       <= COL_INIT;
      r_key_value <= '0;
      r_key_valid <= 1'b0;
      r_key_pulse <= 1'b0;
    end else begin
      r_key_pulse <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          SCAN: begin
            if (w_idle) begin
              r_col <= {r_col[2:0], r_col[3]};
            end else begin
              r_cap_row  <= w_row;
              r_cap_code <= {row_idx(w_row), col_idx(r_col)};
              r_cnt      <= CNT_ONE;
              r_state    <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            if (w_row == r_cap_row) begin
              r_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == DB_MAX) begin
                r_cnt       <= '0;
                r_state     <= HELD;
                r_key_value <= r_cap_code;
                r_key_valid <= 1'b1;
                r_key_pulse <= 1'b1;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= SCAN;
            end
          end
          HELD: begin
            if (w_idle) begin
              r_cnt   <= CNT_ONE;
              r_state <= RELEASE_DB;
            end
          end
          RELEASE_DB: begin
            if (w_idle) begin
              r_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == DB_MAX) begin
                r_cnt       <= '0;
                r_key_valid <= 1'b0;
                r_state     <= SCAN;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= HELD;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= SCAN;
          end
        endcase
        // Later assignment wins: a corrupted column drive snaps back.
        if (!col_legal(r_col)) r_col <= COL_INIT;
      end
    end
  end

  assign col       = r_col;
  assign key_value = r_key_value;
  assign key_valid = r_key_valid;
  assign key_pulse = r_key_pulse;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with 16-clk ticks and 3-tick debounce.
module tb_keypad_scan_4x4;

  logic       clk;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_pulse;

  int checks;
  int errors;
  int pulse_cnt;
  logic [3:0] tb_div;

  keypad_scan_4x4 #(
    .SCAN_DIV_BITS  (4),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_value (key_value),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference divider: the tick is high while it reads 8.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_div <= 4'd0;
    else          tb_div <= tb_div + 4'd1;
  end

  always @(negedge clk) begin
    if (key_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next tick-qualified edge and settle.
  task automatic tick();
    do @(negedge clk); while (tb_div != 4'd8);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] exp_col [5];

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    reset_n   = 1'b0;
    row       = 4'b1111;
    exp_col   = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};

    repeat (3) @(negedge clk);
    chk("rst_col",   8'(col),       8'h0e);
    chk("rst_value", 8'(key_value), 8'h00);
    chk("rst_valid", 8'(key_valid), 8'h00);
    chk("rst_pulse", 8'(key_pulse), 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle_col%0d", i), 8'(col), 8'(exp_col[i]));
      chk("idle_valid", 8'(key_valid), 8'h00);
    end
    chk("idle_pulses", 8'(pulse_cnt), 8'd0);

    row = 4'b1011;
    tick();
    chk("press1_col",   8'(col),       8'h0d);
    chk("press1_valid", 8'(key_valid), 8'h00);
    tick();
    chk("press2_valid", 8'(key_valid), 8'h00);
    chk("press2_pulse", 8'(key_pulse), 8'h00);
    tick();
    chk("press3_valid", 8'(key_valid), 8'h01);
    chk("press3_value", 8'(key_value), 8'd9);
    chk("press3_pulse", 8'(key_pulse), 8'h01);
    chk("press3_col",   8'(col),       8'h0d);
    @(posedge clk);
    #1;
    chk("pulse_width",  8'(key_pulse), 8'h00);
    chk("press_pulses", 8'(pulse_cnt), 8'd1);

    row = 4'b1111;
    tick();
    chk("glitch_valid1", 8'(key_valid), 8'h01);
    row = 4'b1011;
    tick();
    chk("glitch_valid2", 8'(key_valid), 8'h01);
    row = 4'b1110;
    tick();
    chk("held_other_value", 8'(key_value), 8'd9);
    chk("held_other_valid", 8'(key_valid), 8'h01);
    chk("glitch_pulses",    8'(pulse_cnt), 8'd1);

    row = 4'b1111;
    ticks(2);
    chk("rel2_valid", 8'(key_valid), 8'h01);
    tick();
    chk("rel3_valid", 8'(key_valid), 8'h00);
    chk("rel3_value", 8'(key_value), 8'd9);
    chk("rel3_col",   8'(col),       8'h0d);
    tick();
    chk("resume_col", 8'(col),       8'h0b);

    row = 4'b1011;
    tick();
    chk("bounce1_col", 8'(col), 8'h0b);
    row = 4'b1111;
    tick();
    chk("bounce2_col", 8'(col), 8'h0b);
    row = 4'b1011;
    tick();
    chk("bounce3_col", 8'(col), 8'h0b);
    row = 4'b1111;
    tick();
    chk("bounce4_col", 8'(col), 8'h0b);
    tick();
    chk("bounce5_col",    8'(col),       8'h07);
    chk("bounce_valid",   8'(key_valid), 8'h00);
    chk("bounce_pulses",  8'(pulse_cnt), 8'd1);

    row = 4'b1001;
    ticks(3);
    chk("two_row_value",  8'(key_value), 8'd7);
    chk("two_row_valid",  8'(key_valid), 8'h01);
    @(posedge clk);
    #1;
    chk("two_row_pulses", 8'(pulse_cnt), 8'd2);
    row = 4'b1111;
    ticks(3);
    chk("two_rel_valid", 8'(key_valid), 8'h00);
    chk("two_rel_value", 8'(key_value), 8'd7);
    chk("two_rel_col",   8'(col),       8'h07);

    row = 4'b1011;
    tick();
    chk("pdb_col", 8'(col), 8'h07);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    row     = 4'b1111;
    #1;
    chk("mid_rst_col",   8'(col),       8'h0e);
    chk("mid_rst_value", 8'(key_value), 8'h00);
    chk("mid_rst_valid", 8'(key_valid), 8'h00);
    chk("mid_rst_pulse", 8'(key_pulse), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    ticks(3);
    chk("post_rst_col",    8'(col),       8'h07);
    chk("post_rst_valid",  8'(key_valid), 8'h00);
    chk("post_rst_pulses", 8'(pulse_cnt), 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
